sram_pixel_fetch: RTL and testbench
===================================

SRAM_PIXEL_FETCH -- requirements
Module: sram_pixel_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word-address width (equal to sram_pkg::SRAM_ADDR_COUNT).
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width; holds four 4-bit palette indices per word.
REQ-003 SHALL have parameter PIX_W, default 4, palette-index width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: i_clk in 1, rising-edge clock; i_rst in 1, asynchronous active-high reset.
REQ-005 SHALL have port i_req_valid in 1, pixel fetch request this cycle.
REQ-006 SHALL have port i_sram_addr in ADDR_W, word address from the address encoder.
REQ-007 SHALL have port i_sub_index in 2, pixel_index[1:0], aligned by the caller with i_sram_addr.
REQ-008 SHALL have port o_req_ready out 1, request accepted when high with i_req_valid.
REQ-009 SHALL have port o_pix_valid out 1, o_pix_index/o_pix_transparent are valid.
REQ-010 SHALL have port o_pix_index out PIX_W, fetched palette index.
REQ-011 SHALL have port o_pix_transparent out 1, high when o_pix_index == 0.
REQ-012 SHALL have SRAM ports o_SRAM_ADDR out ADDR_W, io_SRAM_DQ inout DATA_W, o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N and o_SRAM_UB_N, each out 1.
REQ-013 SHALL have loader ports i_wr_valid in 1, i_wr_addr in ADDR_W, i_wr_data in DATA_W and o_wr_ready out 1; these are present only under SRAM_FETCH_WRITE_EN.

Function
REQ-014 SHALL implement FSM states S_READ, S_WRITE, S_TURN.
- S_READ: reads enabled; o_req_ready = 1.
- S_WRITE: lasts one cycle; DQ driven; WE_N = 0.
- S_TURN: lasts one cycle; DQ released; o_req_ready = 0.
REQ-015 Transitions SHALL be:
- S_READ->S_WRITE when i_wr_valid && !i_req_valid.
- S_WRITE->S_TURN unconditionally.
- S_TURN->S_READ unconditionally.
REQ-016 Reads SHALL have priority: when i_req_valid && i_wr_valid in S_READ, the read is accepted and o_wr_ready = 0.
REQ-017 o_wr_ready SHALL be 1 only in S_READ with !i_req_valid; a write is accepted on i_wr_valid && o_wr_ready.
REQ-018 On an accepted read (cycle N), i_sram_addr and i_sub_index SHALL be registered at N; o_SRAM_ADDR holds that address during N+1; DQ is sampled at the end of N+1.
REQ-019 o_pix_valid SHALL assert in cycle N+2, a fixed latency of 2; back-to-back requests yield one pixel per cycle.
REQ-020 Nibble select SHALL map sub 0->DQ[3:0], 1->[7:4], 2->[11:8], 3->[15:12], using the sub-index delayed with the address.
REQ-021 When idle, o_SRAM_ADDR SHALL hold its last value.
REQ-022 In all states: CE_N = 0, LB_N = 0, UB_N = 0; OE_N = 0 except in S_WRITE; WE_N = 1 except in S_WRITE.
REQ-023 io_SRAM_DQ SHALL be high-Z except in S_WRITE, where it drives the registered i_wr_data; o_SRAM_ADDR = registered i_wr_addr in S_WRITE.
REQ-024 A request with i_req_valid while o_req_ready = 0 SHALL be ignored; no pixel is produced for it.

Reset
REQ-025 On i_rst: state = S_READ, o_pix_valid = 0, o_pix_index = 0, o_pix_transparent = 0, o_SRAM_ADDR = 0, WE_N = 1, DQ = Z, pipeline valids cleared.
REQ-026 Reset mid-operation SHALL discard in-flight reads (no o_pix_valid afterwards) and abort S_WRITE with WE_N = 1 in the same cycle.

Configuration
REQ-027 Macro SRAM_FETCH_WRITE_EN SHALL enable the loader port and the S_WRITE/S_TURN states.
REQ-028 Without SRAM_FETCH_WRITE_EN, the FSM SHALL be absent: o_req_ready = 1, WE_N = 1, DQ permanently high-Z; read behaviour is identical.

Structure
REQ-029 sram_pkg SHALL hold SRAM_DATA_WIDTH = 16, PIXELS_PER_WORD = 4 and the FSM state enum FetchState.
REQ-030 Nibble extraction SHALL be a sub-module pixel_unpack (combinational: word, sub-index -> index, transparent).

Verification
REQ-031 Preload word 0x4321 at addr 0x00010; request sub 0..3 back-to-back -> indices 1,2,3,4 on four consecutive cycles starting 2 cycles after the first request.
REQ-032 Word 0x0F00 at addr 5, sub 0 -> o_pix_index 0, o_pix_transparent 1; sub 2 -> index 0xF, transparent 0.
REQ-033 i_wr_valid with data 0xABCD at addr 7 while i_req_valid = 0 -> WE_N low exactly one cycle, then TURN with o_req_ready = 0; a read of addr 7 sub 3 then returns 0xA.
REQ-034 i_wr_valid and i_req_valid asserted together for 3 cycles -> three reads served, o_wr_ready = 0 throughout; the write proceeds on the first idle cycle.
REQ-035 Assert i_rst one cycle after a read request -> no o_pix_valid is produced, and all outputs hold their reset values.
REQ-036 Build without SRAM_FETCH_WRITE_EN -> o_req_ready constant 1, WE_N constant 1, REQ-031 passes unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared constants and types for the SRAM pixel fetch slice.
//   SRAM_ADDR_COUNT  word-address width of the external SRAM
//   SRAM_DATA_WIDTH  SRAM data-bus width
//   PIXELS_PER_WORD  palette indices packed into one SRAM word
//   PIX_WIDTH        palette-index width
//   FetchState       fetch FSM state encoding (used when SRAM_FETCH_WRITE_EN is defined)
package sram_pkg;

  localparam int SRAM_ADDR_COUNT = 20;
  localparam int SRAM_DATA_WIDTH = 16;
  localparam int PIXELS_PER_WORD = 4;
  localparam int PIX_WIDTH       = SRAM_DATA_WIDTH / PIXELS_PER_WORD;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_WRITE = 2'd1,
    S_TURN  = 2'd2
  } FetchState;

endpackage

// File: rtl/pixel_unpack.sv
// pixel_unpack: combinational nibble extraction from one SRAM word.
// Ports:
//   i_word         SRAM data word (DATA_W bits, four packed PIX_W indices)
//   i_sub          which index within the word (0 = bits [PIX_W-1:0])
//   o_index        selected palette index
//   o_transparent  high when the selected index is zero
module pixel_unpack #(
  parameter int DATA_W = 16,
  parameter int PIX_W  = 4
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_sub,
  output logic [PIX_W-1:0]  o_index,
  output logic              o_transparent
);

  always_comb begin
    o_index = '0;
    case (i_sub)
      2'd0:    o_index = i_word[0*PIX_W +: PIX_W];
      2'd1:    o_index = i_word[1*PIX_W +: PIX_W];
      2'd2:    o_index = i_word[2*PIX_W +: PIX_W];
      default: o_index = i_word[3*PIX_W +: PIX_W];
    endcase
  end

  assign o_transparent = (o_index == '0);

endmodule

// File: rtl/sram_pixel_fetch.sv
// sram_pixel_fetch: fetches 4-bit palette indices from an asynchronous SRAM
// with a fixed two-cycle latency, one pixel per cycle when requests are
// back to back.
//
// Optional feature: define SRAM_FETCH_WRITE_EN to add a loader write port
// and the S_READ/S_WRITE/S_TURN FSM. Without it the block is read-only:
// o_req_ready = 1, WE_N = 1, DQ never driven.
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high at the rising edge; ready never depends on the same-port valid.
// Reads have priority over loader writes (o_wr_ready drops while
// i_req_valid is high).
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_req_valid/o_req_ready      pixel request handshake
//   i_sram_addr, i_sub_index     word address and pixel-in-word for a request
//   o_pix_valid/o_pix_index/o_pix_transparent  fetched pixel (request + 2)
//   o_SRAM_*, io_SRAM_DQ         external SRAM pins (active-low controls)
//   i_wr_valid/i_wr_addr/i_wr_data/o_wr_ready  loader port (write-enable build)
//   o_dbg_state                  current FSM state (S_READ when no FSM)
module sram_pixel_fetch
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_COUNT,
  parameter int DATA_W = SRAM_DATA_WIDTH,
  parameter int PIX_W  = PIX_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_sram_addr,
  input  logic [1:0]        i_sub_index,
  output logic              o_req_ready,
  output logic              o_pix_valid,
  output logic [PIX_W-1:0]  o_pix_index,
  output logic              o_pix_transparent,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N,
`ifdef SRAM_FETCH_WRITE_EN
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
`endif
  output FetchState         o_dbg_state
);

  // Read pipeline: stage 1 presents the address, stage 2 holds the pixel.
  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        sub_q;
  logic              rd_valid_q;
  logic              pix_valid_q;
  logic [PIX_W-1:0]  pix_index_q;
  logic              pix_trans_q;
  logic [PIX_W-1:0]  unpack_index;
  logic              unpack_trans;
  logic              req_accept;

  assign req_accept = i_req_valid && o_req_ready;

  // The pixel is unpacked straight off the bus and registered at the end of
  // the address cycle, so the outputs are plain flops.
  pixel_unpack #(
    .DATA_W (DATA_W),
    .PIX_W  (PIX_W)
  ) u_unpack (
    .i_word        (io_SRAM_DQ),
    .i_sub         (sub_q),
    .o_index       (unpack_index),
    .o_transparent (unpack_trans)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_addr_q   <= '0;
      sub_q       <= '0;
      rd_valid_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_index_q <= '0;
      pix_trans_q <= 1'b0;
    end else begin
      rd_valid_q  <= req_accept;
      pix_valid_q <= rd_valid_q;
      // Address is only updated on accept so it holds when idle.
      if (req_accept) begin
        rd_addr_q <= i_sram_addr;
        sub_q     <= i_sub_index;
      end
      if (rd_valid_q) begin
        pix_index_q <= unpack_index;
        pix_trans_q <= unpack_trans;
      end
    end
  end

  assign o_pix_valid       = pix_valid_q;
  assign o_pix_index       = pix_index_q;
  assign o_pix_transparent = pix_trans_q;

  assign o_SRAM_CE_N = 1'b0;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;

`ifdef SRAM_FETCH_WRITE_EN
  FetchState         state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              dq_oe;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_READ;
    end else begin
      state_q <= state_d;
    end
  end

  // Loader capture: the write is performed in the following S_WRITE cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (i_wr_valid && o_wr_ready) begin
      wr_addr_q <= i_wr_addr;
      wr_data_q <= i_wr_data;
    end
  end

  // Next-state logic; S_TURN gives the bus a dead cycle before reads resume.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_READ:  if (i_wr_valid && !i_req_valid) state_d = S_WRITE;
      S_WRITE: state_d = S_TURN;
      S_TURN:  state_d = S_READ;
      default: state_d = S_READ;
    endcase
  end

  // Output logic
  always_comb begin
    o_req_ready = 1'b0;
    o_wr_ready  = 1'b0;
    o_SRAM_WE_N = 1'b1;
    o_SRAM_OE_N = 1'b0;
    dq_oe       = 1'b0;
    o_SRAM_ADDR = rd_addr_q;
    case (state_q)
      S_READ: begin
        o_req_ready = 1'b1;
        o_wr_ready  = !i_req_valid;
      end
      S_WRITE: begin
        o_SRAM_WE_N = 1'b0;
        o_SRAM_OE_N = 1'b1;
        dq_oe       = 1'b1;
        o_SRAM_ADDR = wr_addr_q;
      end
      default: ;
    endcase
  end

  assign io_SRAM_DQ  = dq_oe ? wr_data_q : {DATA_W{1'bz}};
  assign o_dbg_state = state_q;
`else
  assign o_req_ready = 1'b1;
  assign o_SRAM_WE_N = 1'b1;
  assign o_SRAM_OE_N = 1'b0;
  assign o_SRAM_ADDR = rd_addr_q;
  assign io_SRAM_DQ  = {DATA_W{1'bz}};
  assign o_dbg_state = S_READ;
`endif

endmodule

// File: tb/tb_sram_pixel_fetch.sv
// tb_sram_pixel_fetch: directed bench for sram_pixel_fetch with a small
// asynchronous SRAM model. Write-path scenarios are built only when
// SRAM_FETCH_WRITE_EN is defined.
module tb_sram_pixel_fetch;
  import sram_pkg::*;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int PIX_W  = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] req_addr  = '0;
  logic [1:0]        req_sub   = '0;
  logic              req_ready;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_index;
  logic              pix_trans;
  logic [ADDR_W-1:0] sram_addr;
  wire  [DATA_W-1:0] sram_dq;
  logic              sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n;
  FetchState         dbg_state;
`ifdef SRAM_FETCH_WRITE_EN
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr  = '0;
  logic [DATA_W-1:0] wr_data  = '0;
  logic              wr_ready;
`endif

  int errors = 0;
  int checks = 0;
  logic [PIX_W-1:0] exp_q[$];

  sram_pixel_fetch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PIX_W  (PIX_W)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_req_valid       (req_valid),
    .i_sram_addr       (req_addr),
    .i_sub_index       (req_sub),
    .o_req_ready       (req_ready),
    .o_pix_valid       (pix_valid),
    .o_pix_index       (pix_index),
    .o_pix_transparent (pix_trans),
    .o_SRAM_ADDR       (sram_addr),
    .io_SRAM_DQ        (sram_dq),
    .o_SRAM_WE_N       (sram_we_n),
    .o_SRAM_CE_N       (sram_ce_n),
    .o_SRAM_OE_N       (sram_oe_n),
    .o_SRAM_LB_N       (sram_lb_n),
    .o_SRAM_UB_N       (sram_ub_n),
`ifdef SRAM_FETCH_WRITE_EN
    .i_wr_valid        (wr_valid),
    .i_wr_addr         (wr_addr),
    .i_wr_data         (wr_data),
    .o_wr_ready        (wr_ready),
`endif
    .o_dbg_state       (dbg_state)
  );

  // Asynchronous SRAM model (low 8 address bits decoded)
  logic [DATA_W-1:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : {DATA_W{1'bz}};
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq;

  // Each window starts 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (pix_valid !== 1'b0 || pix_index !== 4'h0 || pix_trans !== 1'b0) begin
      errors++;
      $display("FAIL reset_pix got v=%b i=%h t=%b exp v=0 i=0 t=0", pix_valid, pix_index, pix_trans);
    end
    checks++;
    if (sram_addr !== 20'h0 || sram_we_n !== 1'b1 || sram_ce_n !== 1'b0 || sram_lb_n !== 1'b0 ||
        sram_ub_n !== 1'b0 || sram_oe_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_sram got a=%h we=%b ce=%b oe=%b lb=%b ub=%b exp a=0 we=1 ce=0 oe=0 lb=0 ub=0",
               sram_addr, sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n);
    end
    checks++;
    if (dbg_state !== S_READ || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got st=%0d rdy=%b exp st=0 rdy=1", dbg_state, req_ready);
    end
    rst = 1'b0;
  endtask

  // Word 0x4321 at 0x10, subs 0..3 back to back -> 1,2,3,4 from window 2.
  task automatic test_back_to_back();
    logic [PIX_W-1:0] exp_tab [4];
    logic [PIX_W-1:0] e;
    exp_tab = '{4'h1, 4'h2, 4'h3, 4'h4};
    mem[8'h10] = 16'h4321;
    for (int i = 0; i < 7; i++) begin
      tick();
      req_valid = (i < 4);
      req_addr  = 20'h00010;
      req_sub   = 2'(i);
      if (i < 4) exp_q.push_back(exp_tab[i]);
      #1;
      if (i == 1) begin
        checks++;
        if (sram_addr !== 20'h00010) begin
          errors++;
          $display("FAIL b2b_addr got %h exp 00010", sram_addr);
        end
      end
      if (i >= 2 && i <= 5) begin
        e = exp_q.pop_front();
        checks++;
        if (pix_valid !== 1'b1 || pix_index !== e) begin
          errors++;
          $display("FAIL b2b_pix%0d got v=%b i=%h exp v=1 i=%h", i, pix_valid, pix_index, e);
        end
      end else begin
        checks++;
        if (pix_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle%0d got v=%b exp v=0", i, pix_valid);
        end
      end
    end
    req_valid = 1'b0;
  endtask

  // Word 0x0F00 at 5: sub 0 -> 0 transparent, sub 2 -> F opaque.
  task automatic test_transparent();
    mem[8'h05] = 16'h0F00;
    for (int i = 0; i < 5; i++) begin
      tick();
      req_valid = (i < 2);
      req_addr  = 20'h00005;
      req_sub   = (i == 0) ? 2'd0 : 2'd2;
      #1;
      if (i == 2) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_index !== 4'h0 || pix_trans !== 1'b1) begin
          errors++;
          $display("FAIL transp_sub0 got v=%b i=%h t=%b exp v=1 i=0 t=1", pix_valid, pix_index, pix_trans);
        end
      end
      if (i == 3) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_index !== 4'hF || pix_trans !== 1'b0) begin
          errors++;
          $display("FAIL transp_sub2 got v=%b i=%h t=%b exp v=1 i=F t=0", pix_valid, pix_index, pix_trans);
        end
      end
      if (i == 4) begin
        checks++;
        if (pix_valid !== 1'b0) begin
          errors++;
          $display("FAIL transp_idle got v=%b exp v=0", pix_valid);
        end
      end
    end
    req_valid = 1'b0;
  endtask

  // Reset one cycle after a read request drops the in-flight read.
  task automatic test_reset_mid_read();
    tick();
    req_valid = 1'b1;
    req_addr  = 20'h00010;
    req_sub   = 2'd3;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (pix_valid !== 1'b0 || pix_index !== 4'h0 || pix_trans !== 1'b0 || sram_addr !== 20'h0 ||
        sram_we_n !== 1'b1 || dbg_state !== S_READ) begin
      errors++;
      $display("FAIL rst_mid_read got v=%b i=%h t=%b a=%h we=%b st=%0d exp v=0 i=0 t=0 a=0 we=1 st=0",
               pix_valid, pix_index, pix_trans, sram_addr, sram_we_n, dbg_state);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pix_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_pix%0d got v=%b exp v=0", i, pix_valid);
      end
    end
  endtask

`ifdef SRAM_FETCH_WRITE_EN
  // Write 0xABCD to 7, check the WRITE/TURN sequence, an ignored request in
  // TURN, then read back sub 3 -> A.
  task automatic test_write();
    for (int i = 0; i < 6; i++) begin
      tick();
      wr_valid  = (i == 0);
      wr_addr   = 20'h00007;
      wr_data   = 16'hABCD;
      req_valid = (i == 2) || (i == 3);
      req_addr  = (i == 2) ? 20'h00010 : 20'h00007;
      req_sub   = (i == 2) ? 2'd0 : 2'd3;
      #1;
      case (i)
        0: begin
          checks++;
          if (wr_ready !== 1'b1 || sram_we_n !== 1'b1 || dbg_state !== S_READ) begin
            errors++;
            $display("FAIL wr_accept got wrdy=%b we=%b st=%0d exp wrdy=1 we=1 st=0", wr_ready, sram_we_n, dbg_state);
          end
        end
        1: begin
          checks++;
          if (sram_we_n !== 1'b0 || sram_oe_n !== 1'b1 || req_ready !== 1'b0 || dbg_state !== S_WRITE ||
              sram_addr !== 20'h00007 || sram_dq !== 16'hABCD) begin
            errors++;
            $display("FAIL wr_cycle got we=%b oe=%b rdy=%b st=%0d a=%h dq=%h exp we=0 oe=1 rdy=0 st=1 a=7 dq=ABCD",
                     sram_we_n, sram_oe_n, req_ready, dbg_state, sram_addr, sram_dq);
          end
        end
        2: begin
          checks++;
          if (sram_we_n !== 1'b1 || req_ready !== 1'b0 || wr_ready !== 1'b0 || dbg_state !== S_TURN) begin
            errors++;
            $display("FAIL wr_turn got we=%b rdy=%b wrdy=%b st=%0d exp we=1 rdy=0 wrdy=0 st=2",
                     sram_we_n, req_ready, wr_ready, dbg_state);
          end
        end
        3: begin
          checks++;
          if (req_ready !== 1'b1 || dbg_state !== S_READ) begin
            errors++;
            $display("FAIL wr_back got rdy=%b st=%0d exp rdy=1 st=0", req_ready, dbg_state);
          end
        end
        4: begin
          checks++;
          if (pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL turn_req_ignored got v=%b exp v=0", pix_valid);
          end
        end
        default: begin
          checks++;
          if (pix_valid !== 1'b1 || pix_index !== 4'hA) begin
            errors++;
            $display("FAIL wr_readback got v=%b i=%h exp v=1 i=A", pix_valid, pix_index);
          end
        end
      endcase
    end
    req_valid = 1'b0;
  endtask

  // Read and write requested together for 3 cycles: reads win, the write
  // (0x1234 to 8) goes on the first idle cycle; read back sub 1 -> 3.
  task automatic test_read_priority();
    logic [PIX_W-1:0] exp_tab [3];
    exp_tab = '{4'h1, 4'h2, 4'h3};
    for (int i = 0; i < 9; i++) begin
      tick();
      wr_valid  = (i < 4);
      wr_addr   = 20'h00008;
      wr_data   = 16'h1234;
      req_valid = (i < 3) || (i == 6);
      req_addr  = (i == 6) ? 20'h00008 : 20'h00010;
      req_sub   = (i == 6) ? 2'd1 : 2'(i);
      #1;
      if (i < 3) begin
        checks++;
        if (wr_ready !== 1'b0 || req_ready !== 1'b1 || sram_we_n !== 1'b1) begin
          errors++;
          $display("FAIL prio_hold%0d got wrdy=%b rdy=%b we=%b exp wrdy=0 rdy=1 we=1", i, wr_ready, req_ready, sram_we_n);
        end
      end
      if (i >= 2 && i <= 4) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_index !== exp_tab[i-2]) begin
          errors++;
          $display("FAIL prio_pix%0d got v=%b i=%h exp v=1 i=%h", i, pix_valid, pix_index, exp_tab[i-2]);
        end
      end
      if (i == 3) begin
        checks++;
        if (wr_ready !== 1'b1) begin
          errors++;
          $display("FAIL prio_idle_wr got wrdy=%b exp wrdy=1", wr_ready);
        end
      end
      if (i == 4) begin
        checks++;
        if (sram_we_n !== 1'b0 || sram_addr !== 20'h00008) begin
          errors++;
          $display("FAIL prio_write got we=%b a=%h exp we=0 a=8", sram_we_n, sram_addr);
        end
      end
      if (i == 8) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_index !== 4'h3) begin
          errors++;
          $display("FAIL prio_readback got v=%b i=%h exp v=1 i=3", pix_valid, pix_index);
        end
      end
    end
    wr_valid  = 1'b0;
    req_valid = 1'b0;
  endtask

  // Reset during S_WRITE releases WE_N at once and the word is not stored.
  task automatic test_reset_mid_write();
    tick();
    wr_valid = 1'b1;
    wr_addr  = 20'h00009;
    wr_data  = 16'h5555;
    tick();
    wr_valid = 1'b0;
    checks++;
    if (sram_we_n !== 1'b0) begin
      errors++;
      $display("FAIL rstw_pre got we=%b exp we=0", sram_we_n);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (sram_we_n !== 1'b1 || dbg_state !== S_READ) begin
      errors++;
      $display("FAIL rstw_abort got we=%b st=%0d exp we=1 st=0", sram_we_n, dbg_state);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (mem[8'h09] !== 16'h0000) begin
      errors++;
      $display("FAIL rstw_mem got %h exp 0000", mem[8'h09]);
    end
  endtask
`else
  // Read-only build: ready and WE_N stay constant under any request pattern.
  task automatic test_read_only();
    for (int i = 0; i < 6; i++) begin
      tick();
      req_valid = i[0];
      req_addr  = 20'(i);
      req_sub   = 2'(i);
      #1;
      checks++;
      if (req_ready !== 1'b1 || sram_we_n !== 1'b1 || dbg_state !== S_READ) begin
        errors++;
        $display("FAIL ro_const%0d got rdy=%b we=%b st=%0d exp rdy=1 we=1 st=0", i, req_ready, sram_we_n, dbg_state);
      end
    end
    req_valid = 1'b0;
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_transparent();
    test_reset_mid_read();
`ifdef SRAM_FETCH_WRITE_EN
    test_write();
    test_read_priority();
    test_reset_mid_write();
`else
    test_read_only();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
